fc_argmax: RTL and testbench
============================

Name: fc_argmax

Overview:
- Classification stage directly downstream of the fully connected layer.
- Captures the ten 32-bit class scores when the FC stage signals done.
- Scans the scores serially, one comparison per cycle, to find the winning class.
- Presents the class index and winning score to the host or top-level controller through a valid/ready handshake.

Parameters:
- SCORE_WIDTH, 32, width of each class score; scores are two's-complement signed.
- IDX_WIDTH, 4, width of the class index output; must satisfy 2^IDX_WIDTH >= 10.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- prob_0 .. prob_9  input  SCORE_WIDTH each  class scores from the FC stage, signed.
- fc_done  input  1  FC result valid; level signal, high for as long as the FC stage is enabled.
- class_ready  input  1  consumer accepts the result.
- class_valid  output  1  result available.
- class_id  output  IDX_WIDTH  index (0-9) of the maximum score.
- class_score  output  SCORE_WIDTH  maximum score value, signed.
- busy  output  1  high in SCAN and HOLD.
- overrun  output  1  one-cycle pulse when a new result is dropped.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; class_valid=0, class_id=0, class_score=0, busy=0, overrun=0.
  - fc_done_q=0, scan counter=0, capture registers=0.
- Start event:
  - start = fc_done & ~fc_done_q, where fc_done_q is fc_done registered every cycle.
  - A level held high yields exactly one start.
- IDLE:
  - On start: capture prob_0..prob_9 into internal registers.
  - Set best=prob_0, best_idx=0, cnt=1; go to SCAN.
- SCAN:
  - Each cycle compare reg[cnt] against best as a signed compare.
  - Strictly greater replaces best and best_idx; ties keep the lower index.
  - cnt increments each cycle.
  - When cnt==9 is processed, register the final best into class_score/class_id and set class_valid=1; go to HOLD.
- Latency:
  - Start is sampled at edge E0; SCAN edges are E1..E9.
  - class_valid is high after E9, i.e. 9 cycles after the capture edge, 10 cycles after fc_done rises.
- HOLD:
  - class_valid, class_id and class_score stay stable until class_ready=1.
  - On an edge with class_valid & class_ready: class_valid=0.
  - Then, if start is also true that cycle, capture the new scores and go to SCAN (back-to-back, no bubble); otherwise go to IDLE.
- Overrun:
  - A start while in SCAN, or in HOLD with class_ready=0, is dropped.
  - overrun pulses high for one cycle; captured data and the scan are unaffected.
- Output stability: class_id and class_score keep their last values after the handshake until the next SCAN completes.
- busy = (state != IDLE).
- Reset mid-SCAN or mid-HOLD: immediate return to the reset values; the partial result is discarded.
- After reset, the next rising edge of fc_done is a valid start, because fc_done_q resets to 0.
- Arithmetic:
  - Only comparisons are performed; no adders are needed on the score path.
  - The compare is a full SCORE_WIDTH signed compare (e.g. 0x80000000 is the most negative).

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- When defined:
  - Adds output class_margin, SCORE_WIDTH+1 bits, unsigned, equal to best minus second-best score, computed at full precision with sign extension.
  - Adds a second-best tracker in SCAN: on replacement, the old best becomes the second best; otherwise a candidate greater than second-best replaces it.
  - A tie for maximum gives margin 0.
  - class_margin resets to 0 and updates in the same cycle as class_score.
- When undefined: port and tracker are absent; behaviour is otherwise identical.

Test Plan:
- Distinct scores: prob_k=100*k, fc_done held high 3 cycles.
  - Exactly one start; class_valid high 10 cycles after fc_done rise.
  - class_id=9, class_score=900.
  - class_margin=100 (ARGMAX_MARGIN_EN).
- Signed and tie handling: all scores negative, prob_3=prob_7=-5 (the maximum), others -1000.
  - class_id=3, class_score=0xFFFFFFFB, margin=0.
  - A score of 0x80000000 at index 0 never wins over any other value.
- Handshake hold: class_ready=0 for 20 cycles after valid.
  - Outputs stable and busy=1.
  - Ready=1 for one cycle: class_valid falls next edge, state IDLE.
- Overrun: second fc_done rise during SCAN.
  - overrun pulses for exactly 1 cycle; result still from the first score set.
- Back-to-back: fc_done rises in the same cycle as class_valid&class_ready.
  - New scores captured; new class_valid 9 cycles later; no overrun.
- Reset mid-scan: assert rst at cycle 4 of SCAN.
  - All outputs 0 immediately (asynchronous).
  - Fresh fc_done after release gives a correct result.

Source files
------------

// File: rtl/fc_argmax.sv
// Serial argmax over the ten FC class scores, result offered on a valid/ready handshake.
// Define ARGMAX_MARGIN_EN to add the best-minus-second-best class_margin output.
module fc_argmax #(
  parameter int SCORE_WIDTH = 32,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [SCORE_WIDTH-1:0] prob_0,
  input  logic signed [SCORE_WIDTH-1:0] prob_1,
  input  logic signed [SCORE_WIDTH-1:0] prob_2,
  input  logic signed [SCORE_WIDTH-1:0] prob_3,
  input  logic signed [SCORE_WIDTH-1:0] prob_4,
  input  logic signed [SCORE_WIDTH-1:0] prob_5,
  input  logic signed [SCORE_WIDTH-1:0] prob_6,
  input  logic signed [SCORE_WIDTH-1:0] prob_7,
  input  logic signed [SCORE_WIDTH-1:0] prob_8,
  input  logic signed [SCORE_WIDTH-1:0] prob_9,
  input  logic                          fc_done,
  input  logic                          class_ready,
  output logic                          class_valid,
  output logic        [IDX_WIDTH-1:0]   class_id,
  output logic signed [SCORE_WIDTH-1:0] class_score,
  output logic                          busy,
  output logic                          overrun
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic        [SCORE_WIDTH:0]   class_margin
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [IDX_WIDTH-1:0]          LAST      = IDX_WIDTH'(9);
  localparam logic signed [SCORE_WIDTH-1:0] SCORE_MIN = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

  state_t                          state_q, state_d;
  logic                            fc_done_q, fc_done_d;
  logic        [IDX_WIDTH-1:0]     cnt_q, cnt_d;
  logic signed [SCORE_WIDTH-1:0]   cap_q [10];
  logic signed [SCORE_WIDTH-1:0]   cap_d [10];
  logic signed [SCORE_WIDTH-1:0]   prob_a [10];
  logic signed [SCORE_WIDTH-1:0]   best_q, best_d;
  logic        [IDX_WIDTH-1:0]     best_idx_q, best_idx_d;
  logic                            class_valid_q, class_valid_d;
  logic        [IDX_WIDTH-1:0]     class_id_q, class_id_d;
  logic signed [SCORE_WIDTH-1:0]   class_score_q, class_score_d;
  logic                            overrun_q, overrun_d;

  logic                            start;
  logic                            capture;
  logic signed [SCORE_WIDTH-1:0]   cand;
  logic                            cand_gt;
  logic signed [SCORE_WIDTH-1:0]   scan_best;
  logic        [IDX_WIDTH-1:0]     scan_idx;

`ifdef ARGMAX_MARGIN_EN
  logic signed [SCORE_WIDTH-1:0]   second_q, second_d;
  logic signed [SCORE_WIDTH-1:0]   scan_second;
  logic        [SCORE_WIDTH:0]     margin_q, margin_d;

  // Difference at one extra bit so the most-positive minus most-negative still fits.
  function automatic logic [SCORE_WIDTH:0] margin_of(input logic signed [SCORE_WIDTH-1:0] hi,
                                                     input logic signed [SCORE_WIDTH-1:0] lo);
    logic [SCORE_WIDTH:0] d;
    d = {hi[SCORE_WIDTH-1], hi} - {lo[SCORE_WIDTH-1], lo};
    return d;
  endfunction
`endif

  assign prob_a[0] = prob_0;
  assign prob_a[1] = prob_1;
  assign prob_a[2] = prob_2;
  assign prob_a[3] = prob_3;
  assign prob_a[4] = prob_4;
  assign prob_a[5] = prob_5;
  assign prob_a[6] = prob_6;
  assign prob_a[7] = prob_7;
  assign prob_a[8] = prob_8;
  assign prob_a[9] = prob_9;

  assign start = fc_done & ~fc_done_q;

  always_comb begin
    state_d       = state_q;
    fc_done_d     = fc_done;
    cnt_d         = cnt_q;
    cap_d         = cap_q;
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    class_valid_d = class_valid_q;
    class_id_d    = class_id_q;
    class_score_d = class_score_q;
    overrun_d     = 1'b0;
    capture       = 1'b0;

    cand      = cap_q[cnt_q];
    cand_gt   = cand > best_q;
    scan_best = cand_gt ? cand : best_q;
    scan_idx  = cand_gt ? cnt_q : best_idx_q;
`ifdef ARGMAX_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin_q;
    // A displaced best drops to second place; otherwise the candidate may still beat second.
    scan_second = cand_gt ? best_q : ((cand > second_q) ? cand : second_q);
`endif

    case (state_q)
      IDLE: capture = start;
      SCAN: begin
        overrun_d  = start;
        best_d     = scan_best;
        best_idx_d = scan_idx;
`ifdef ARGMAX_MARGIN_EN
        second_d   = scan_second;
`endif
        if (cnt_q == LAST) begin
          cnt_d         = '0;
          class_valid_d = 1'b1;
          class_id_d    = scan_idx;
          class_score_d = scan_best;
`ifdef ARGMAX_MARGIN_EN
          margin_d      = margin_of(scan_best, scan_second);
`endif
          state_d       = HOLD;
        end else begin
          cnt_d = cnt_q + IDX_WIDTH'(1);
        end
      end
      HOLD: begin
        if (class_ready) begin
          class_valid_d = 1'b0;
          capture       = start;
          if (!start) state_d = IDLE;
        end else begin
          overrun_d = start;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      cap_d      = prob_a;
      best_d     = prob_0;
      best_idx_d = '0;
      cnt_d      = IDX_WIDTH'(1);
`ifdef ARGMAX_MARGIN_EN
      second_d   = SCORE_MIN;
`endif
      state_d    = SCAN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fc_done_q     <= 1'b0;
      cnt_q         <= '0;
      cap_q         <= '{default: '0};
      best_q        <= '0;
      best_idx_q    <= '0;
      class_valid_q <= 1'b0;
      class_id_q    <= '0;
      class_score_q <= '0;
      overrun_q     <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_q      <= '0;
      margin_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fc_done_q     <= fc_done_d;
      cnt_q         <= cnt_d;
      cap_q         <= cap_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      class_valid_q <= class_valid_d;
      class_id_q    <= class_id_d;
      class_score_q <= class_score_d;
      overrun_q     <= overrun_d;
`ifdef ARGMAX_MARGIN_EN
      second_q      <= second_d;
      margin_q      <= margin_d;
`endif
    end
  end

  assign class_valid = class_valid_q;
  assign class_id    = class_id_q;
  assign class_score = class_score_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);
`ifdef ARGMAX_MARGIN_EN
  assign class_margin = margin_q;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: directed scenarios plus randomized score sets.
module tb_fc_argmax;
  localparam int W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fc_done = 1'b0;
  logic               class_ready = 1'b0;
  logic signed [W-1:0] prob [10];
  logic               class_valid;
  logic [3:0]         class_id;
  logic [W-1:0]       class_score;
  logic               busy;
  logic               overrun;
`ifdef ARGMAX_MARGIN_EN
  logic [W:0]         class_margin;
`endif

  typedef struct packed {
    logic [3:0]   id;
    logic [W-1:0] sc;
    logic [W:0]   mg;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   ovr_cnt = 0;

  always #5 clk = ~clk;

  fc_argmax #(.SCORE_WIDTH(W), .IDX_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .prob_0(prob[0]), .prob_1(prob[1]), .prob_2(prob[2]), .prob_3(prob[3]), .prob_4(prob[4]),
    .prob_5(prob[5]), .prob_6(prob[6]), .prob_7(prob[7]), .prob_8(prob[8]), .prob_9(prob[9]),
    .fc_done(fc_done), .class_ready(class_ready),
    .class_valid(class_valid), .class_id(class_id), .class_score(class_score),
    .busy(busy), .overrun(overrun)
`ifdef ARGMAX_MARGIN_EN
    , .class_margin(class_margin)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: winner is the lowest index holding the maximum; second best is the
  // maximum over every other index.
  task automatic push_model();
    exp_t e;
    logic signed [W-1:0] mx, sec;
    int id;
    bit found;
    longint d;
    mx = prob[0];
    foreach (prob[i]) if (prob[i] > mx) mx = prob[i];
    id = 0;
    for (int i = 9; i >= 0; i--) if (prob[i] == mx) id = i;
    found = 0;
    sec = '0;
    for (int i = 0; i < 10; i++)
      if (i != id && (!found || prob[i] > sec)) begin sec = prob[i]; found = 1; end
    d = longint'(mx) - longint'(sec);
    e.id = id[3:0];
    e.sc = mx;
    e.mg = d[W:0];
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int lat, input string name);
    int n;
    n = 0;
    while (!class_valid && n < 40) begin tick(1); n++; end
    check(name, n, lat);
  endtask

  task automatic handshake();
    class_ready = 1'b1;
    tick(1);
    class_ready = 1'b0;
    check("valid_after_hs", class_valid, 0);
  endtask

  task automatic rand_scores(input bit narrow);
    foreach (prob[i]) prob[i] = narrow ? $signed($urandom_range(0, 7)) - 4 : $signed($urandom);
  endtask

  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (!rst && class_valid && class_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=id%0d required=no_result", class_id);
      end else begin
        mon_e = sb.pop_front();
        check("sb_id", class_id, mon_e.id);
        check("sb_score", class_score, mon_e.sc);
`ifdef ARGMAX_MARGIN_EN
        check("sb_margin", class_margin, mon_e.mg);
`endif
      end
    end
  end

  initial begin
    int n, ov0;
    bit stable;
    foreach (prob[i]) prob[i] = '0;
    #2;
    check("rst_valid", class_valid, 0);
    check("rst_id", class_id, 0);
    check("rst_score", class_score, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Distinct ascending scores, fc_done held three cycles
    foreach (prob[i]) prob[i] = 100 * i;
    push_model();
    ov0 = ovr_cnt;
    fc_done = 1'b1;
    n = 0;
    while (!class_valid && n < 40) begin
      tick(1);
      n++;
      if (n == 3) fc_done = 1'b0;
    end
    check("lat_from_rise", n, 10);
    check("asc_id", class_id, 9);
    check("asc_score", class_score, 900);
`ifdef ARGMAX_MARGIN_EN
    check("asc_margin", class_margin, 100);
`endif
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (class_valid !== 1'b1 || busy !== 1'b1 || class_id !== 4'd9 || class_score !== 32'd900)
        stable = 0;
    end
    check("hold_stable", stable, 1);
    handshake();
    check("idle_busy", busy, 0);
    check("id_kept", class_id, 9);
    tick(3);
    check("single_start_busy", busy, 0);
    check("asc_no_overrun", ovr_cnt - ov0, 0);

    // Negative scores with a tie at the maximum
    foreach (prob[i]) prob[i] = -1000;
    prob[3] = -5;
    prob[7] = -5;
    push_model();
    fc_done = 1'b1;
    tick(1);
    fc_done = 1'b0;
    wait_valid(9, "tie_lat");
    check("tie_id", class_id, 3);
    check("tie_score", class_score, 32'hFFFF_FFFB);
`ifdef ARGMAX_MARGIN_EN
    check("tie_margin", class_margin, 0);
`endif
    handshake();

    // Most negative score at index 0 loses to a value just above it
    foreach (prob[i]) prob[i] = 32'h8000_0000;
    prob[5] = 32'h8000_0001;
    push_model();
    fc_done = 1'b1;
    tick(1);
    fc_done = 1'b0;
    wait_valid(9, "min_lat");
    check("min_id", class_id, 5);
    handshake();

    // Second rise during SCAN is dropped
    rand_scores(0);
    push_model();
    ov0 = ovr_cnt;
    fc_done = 1'b1;
    tick(1);
    fc_done = 1'b0;
    tick(2);
    rand_scores(0);
    fc_done = 1'b1;
    tick(1);
    check("ovr_pulse_hi", overrun, 1);
    tick(1);
    check("ovr_pulse_lo", overrun, 0);
    fc_done = 1'b0;
    wait_valid(5, "ovr_lat");
    check("ovr_count", ovr_cnt - ov0, 1);
    handshake();

    // Back-to-back: new rise coincides with the handshake
    rand_scores(1);
    push_model();
    fc_done = 1'b1;
    tick(1);
    fc_done = 1'b0;
    wait_valid(9, "b2b_first_lat");
    ov0 = ovr_cnt;
    rand_scores(1);
    push_model();
    fc_done = 1'b1;
    class_ready = 1'b1;
    tick(1);
    class_ready = 1'b0;
    fc_done = 1'b0;
    check("b2b_valid_low", class_valid, 0);
    check("b2b_busy", busy, 1);
    wait_valid(9, "b2b_lat");
    check("b2b_no_overrun", ovr_cnt - ov0, 0);
    handshake();

    // Asynchronous reset in the middle of a scan
    rand_scores(0);
    fc_done = 1'b1;
    tick(1);
    fc_done = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_id", class_id, 0);
    check("mid_rst_score", class_score, 0);
    check("mid_rst_valid", class_valid, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    rand_scores(0);
    push_model();
    fc_done = 1'b1;
    tick(1);
    fc_done = 1'b0;
    wait_valid(9, "post_rst_lat");
    handshake();

    // Randomized score sets with random consumer delay
    for (int t = 0; t < 12; t++) begin
      rand_scores(t[0]);
      push_model();
      fc_done = 1'b1;
      tick(1);
      fc_done = 1'b0;
      wait_valid(9, "rand_lat");
      tick($urandom_range(0, 3));
      handshake();
    end

    tick(2);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
